// File: rtl/uart_prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// uart_prog_loader_pkg
//   Shared definitions for the UART program loader: loader FSM state
//   encoding, default ROM geometry and header layout, and a small helper
//   that classifies states as "session in progress".
// ---------------------------------------------------------------------------
package uart_prog_loader_pkg;

   // Default word-address width of the instruction ROM (depth = 2**14 words).
   localparam int UPG_ADDR_W = 14;

   // Default width of the length header, in words.
   localparam int UPG_CNT_W  = 16;

   // The length header is two bytes on the wire, least significant first.
   localparam int HDR_BYTES  = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,  // waiting for start
      ST_LEN0 = 3'd1,  // expecting header byte N[7:0]
      ST_LEN1 = 3'd2,  // expecting header byte N[15:8], then decide
      ST_DATA = 3'd3,  // streaming 4*N data bytes into ROM words
      ST_DONE = 3'd4,  // image loaded, core released
      ST_ERR  = 3'd5   // header rejected (image larger than the ROM)
   } upg_state_t;

   // A session is in progress while the header or payload is being received.
   function automatic logic state_is_busy(input upg_state_t s);
      return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
   endfunction

endpackage

// File: rtl/uart_prog_loader_packer.sv
// ---------------------------------------------------------------------------
// upg_word_packer
//   Collects a little-endian byte stream into 32-bit words. The first byte
//   of each word lands in word[7:0], the fourth in word[31:24]. A 2-bit lane
//   counter tracks the position inside the current word and wraps 3->0.
//
//   word_valid is combinational: it is high in the same cycle as the fourth
//   byte's strobe, with word already carrying that byte in [31:24]. The
//   caller registers word/word_valid, which gives the one-cycle write latency.
//
// Ports
//   clk         in   1   system clock
//   rstn        in   1   synchronous active-low reset
//   clear       in   1   drop any partial word and restart at lane 0
//   byte_valid  in   1   data_byte is a payload byte to be placed
//   data_byte   in   8   payload byte
//   word_valid  out  1   fourth byte of a word is being presented now
//   word        out  32  assembled word (valid while word_valid is high)
// ---------------------------------------------------------------------------
module upg_word_packer (
   input  logic        clk,
   input  logic        rstn,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  data_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  lane_q;
   // Lower three bytes of the word being assembled; the top byte is never
   // stored, it is taken straight from data_byte when the word completes.
   logic [23:0] low_q;

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         lane_q <= 2'd0;
         low_q  <= 24'd0;
      end else if (byte_valid) begin
         lane_q <= lane_q + 2'd1;
         case (lane_q)
            2'd0:    low_q[7:0]   <= data_byte;
            2'd1:    low_q[15:8]  <= data_byte;
            2'd2:    low_q[23:16] <= data_byte;
            default: ;
         endcase
      end
   end

   assign word_valid = byte_valid && (lane_q == 2'd3);
   assign word       = {data_byte, low_q};

endmodule

// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//   Loads a program image into the instruction ROM from a UART byte stream
//   and holds the CPU core in reset until the image is complete.
//
//   Stream: 2 header bytes giving the word count N (little-endian), then
//   4*N payload bytes, each word little-endian. N == 0 completes at once;
//   N larger than the ROM depth is rejected and the payload is ignored.
//
//   Handshake: rx_valid is a one-cycle strobe with no ready/backpressure.
//   A byte is consumed in the cycle rx_valid is high (back-to-back strobes
//   are legal); it is ignored in IDLE, DONE and ERR, and dropped if start
//   is high in the same cycle. upg_wen_o is a one-cycle pulse, with
//   upg_adr_o/upg_dat_o valid in that cycle and held afterwards.
//
// Ports
//   clk         in   1       system clock
//   rstn        in   1       synchronous active-low reset
//   start       in   1       pulse: begin or restart a load session
//   rx_valid    in   1       strobe: rx_byte holds a received byte
//   rx_byte     in   8       received UART byte
//   upg_wen_o   out  1       ROM write enable, one pulse per word
//   upg_adr_o   out  ADDR_W  ROM word address
//   upg_dat_o   out  32      ROM write data
//   upg_done_o  out  1       image loaded (sticky until start/reset)
//   busy_o      out  1       header or payload being received
//   err_o       out  1       header rejected (sticky until start/reset)
//   cpu_rstn_o  out  1       core reset, released one cycle after done
//   state_o     out  3       current loader FSM state (debug)
// ---------------------------------------------------------------------------
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int ADDR_W = UPG_ADDR_W,
   parameter int CNT_W  = UPG_CNT_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              upg_wen_o,
   output logic [ADDR_W-1:0] upg_adr_o,
   output logic [31:0]       upg_dat_o,
   output logic              upg_done_o,
   output logic              busy_o,
   output logic              err_o,
   output logic              cpu_rstn_o,
   output upg_state_t        state_o
);

   localparam int HDR_W = HDR_BYTES * 8;

   // ROM depth in words, at the header compare width. N equal to this is
   // still a legal image, which is why the word index carries one extra bit.
   localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(1) << ADDR_W;

   upg_state_t        state_q;
   upg_state_t        state_d;

   logic [7:0]        len_lo_q;   // N[7:0], captured in LEN0
   logic [CNT_W-1:0]  len_q;      // full N, captured in LEN1
   logic [ADDR_W:0]   idx_q;      // index of the next word to write

   logic              byte_ok;
   logic [HDR_W-1:0]  hdr_raw;
   logic [CNT_W:0]    hdr_n;
   logic              hdr_zero;
   logic              hdr_big;
   logic              last_word;

   logic              pk_byte_valid;
   logic              pk_word_valid;
   logic [31:0]       pk_word;

   logic              take_lo;
   logic              take_hi;
   logic              write_word;
   logic              set_done;
   logic              set_err;

   // A byte arriving together with start belongs to no session.
   assign byte_ok = rx_valid && !start;

   // Header as it stands while the LEN1 byte is on rx_byte.
   assign hdr_raw  = HDR_W'({rx_byte, len_lo_q});
   assign hdr_n    = {1'b0, CNT_W'(hdr_raw)};
   assign hdr_zero = (hdr_n == '0);
   assign hdr_big  = (hdr_n > MAX_WORDS);

   // The word being completed now is word N-1.
   assign last_word = ((CNT_W+1)'(idx_q) + (CNT_W+1)'(1)) == {1'b0, len_q};

   assign pk_byte_valid = byte_ok && (state_q == ST_DATA);

   upg_word_packer u_packer (
      .clk        (clk),
      .rstn       (rstn),
      .clear      (start),
      .byte_valid (pk_byte_valid),
      .data_byte  (rx_byte),
      .word_valid (pk_word_valid),
      .word       (pk_word)
   );

   // -----------------------------------------------------------------------
   // FSM: next state and per-cycle action strobes
   // -----------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      take_lo    = 1'b0;
      take_hi    = 1'b0;
      write_word = 1'b0;
      set_done   = 1'b0;
      set_err    = 1'b0;

      case (state_q)
         ST_IDLE: ;
         ST_LEN0: begin
            if (byte_ok) begin
               take_lo = 1'b1;
               state_d = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (byte_ok) begin
               take_hi = 1'b1;
               if (hdr_zero) begin
                  set_done = 1'b1;
                  state_d  = ST_DONE;
               end else if (hdr_big) begin
                  set_err = 1'b1;
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (pk_word_valid) begin
               write_word = 1'b1;
               if (last_word) begin
                  set_done = 1'b1;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_DONE: ;
         ST_ERR:  ;
         default: state_d = ST_IDLE;
      endcase

      // start wins from any state, including mid-payload.
      if (start) begin
         state_d = ST_LEN0;
      end
   end

   // -----------------------------------------------------------------------
   // State register and datapath
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         len_lo_q   <= 8'd0;
         len_q      <= '0;
         idx_q      <= '0;
         upg_wen_o  <= 1'b0;
         upg_adr_o  <= '0;
         upg_dat_o  <= 32'd0;
         upg_done_o <= 1'b0;
         err_o      <= 1'b0;
         cpu_rstn_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         upg_wen_o  <= 1'b0;
         // Core leaves reset one cycle after the image is complete.
         cpu_rstn_o <= upg_done_o;

         if (take_lo) begin
            len_lo_q <= rx_byte;
         end
         if (take_hi) begin
            len_q <= CNT_W'(hdr_raw);
         end

         if (write_word) begin
            upg_wen_o <= 1'b1;
            upg_adr_o <= idx_q[ADDR_W-1:0];
            upg_dat_o <= pk_word;
            idx_q     <= idx_q + (ADDR_W+1)'(1);
         end

         if (set_done) begin
            upg_done_o <= 1'b1;
         end
         if (set_err) begin
            err_o <= 1'b1;
         end

         // A write registered on the previous edge is already on the
         // outputs and is left to complete; only session status is cleared.
         if (start) begin
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
            idx_q      <= '0;
         end
      end
   end

   assign busy_o  = state_is_busy(state_q);
   assign state_o = state_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//   Self-checking bench for uart_prog_loader. Expected ROM writes are
//   derived from the byte stream (word k = bytes 4k..4k+3, little-endian,
//   written one cycle after its last byte) and queued as they are issued;
//   a monitor pops and compares on every write pulse.
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;
   import uart_prog_loader_pkg::*;

   localparam int ADDR_W = 14;
   localparam int CNT_W  = 16;
   localparam int MAX_N  = 1 << ADDR_W;
   localparam int W      = 32 + ADDR_W + 32;   // {cycle, adr, dat}

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic              start    = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_byte  = 8'd0;
   logic              upg_wen_o;
   logic [ADDR_W-1:0] upg_adr_o;
   logic [31:0]       upg_dat_o;
   logic              upg_done_o;
   logic              busy_o;
   logic              err_o;
   logic              cpu_rstn_o;
   upg_state_t        state_o;

   uart_prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .upg_wen_o  (upg_wen_o),
      .upg_adr_o  (upg_adr_o),
      .upg_dat_o  (upg_dat_o),
      .upg_done_o (upg_done_o),
      .busy_o     (busy_o),
      .err_o      (err_o),
      .cpu_rstn_o (cpu_rstn_o),
      .state_o    (state_o)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [7:0]   data_bytes[$];
   int           checks = 0;
   int           passed = 0;
   logic         mon_en = 1'b0;
   logic         exp_done_wen = 1'b0;
   logic         rstn_s = 1'b0;
   logic         done_prev = 1'b0;

   function automatic void check(input string name, input logic [W-1:0] act,
                                 input logic [W-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   always @(posedge clk) rstn_s <= rstn;

   // Monitor: runs on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (upg_wen_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_write: got adr %h dat %h at cycle %0d expected no write",
                        upg_adr_o, upg_dat_o, cyc);
            end else begin
               check("rom_write", {32'(cyc), upg_adr_o, upg_dat_o}, exp_q.pop_front());
            end
         end
         // Core reset follows done with one cycle of delay and drops in reset.
         check("cpu_rstn", W'(cpu_rstn_o), W'(rstn_s & done_prev));
         if (upg_done_o && !done_prev)
            check("done_with_wen", W'(upg_wen_o), W'(exp_done_wen));
      end
      done_prev = upg_done_o;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic start_pulse(input bit with_byte);
      start = 1'b1;
      if (with_byte) begin
         rx_valid = 1'b1;
         rx_byte  = 8'($urandom_range(0, 255));
      end
      tick();
      start    = 1'b0;
      rx_valid = 1'b0;
   endtask

   function automatic bit model_done(input int n);
      return (n == 0) || (n <= MAX_N && data_bytes.size() >= 4 * n);
   endfunction

   function automatic bit model_err(input int n);
      return n > MAX_N;
   endfunction

   // Start a session, send header N and every byte in data_bytes.
   task automatic run_session(input int n, input int gapmax, input bit start_byte);
      logic [15:0] nn;
      bit          n_ok;
      nn           = 16'(n);
      n_ok         = (n != 0) && (n <= MAX_N);
      exp_done_wen = (n != 0);
      start_pulse(start_byte);
      send_byte(nn[7:0]);
      idle($urandom_range(0, gapmax));
      send_byte(nn[15:8]);
      idle($urandom_range(0, gapmax));
      for (int i = 0; i < data_bytes.size(); i++) begin
         if (n_ok && (i % 4 == 3) && (i / 4 < n))
            exp_q.push_back({32'(cyc + 1), ADDR_W'(i / 4),
                             data_bytes[i], data_bytes[i-1], data_bytes[i-2], data_bytes[i-3]});
         send_byte(data_bytes[i]);
         idle($urandom_range(0, gapmax));
      end
   endtask

   task automatic end_check(input bit exp_done, input bit exp_err);
      idle(2);
      check("done", W'(upg_done_o), W'(exp_done));
      check("err", W'(err_o), W'(exp_err));
      check("busy", W'(busy_o), W'(!(exp_done || exp_err)));
      check("cpu_rstn_level", W'(cpu_rstn_o), W'(exp_done));
      check("writes_drained", W'(exp_q.size()), W'(0));
   endtask

   task automatic fill_random(input int count);
      data_bytes.delete();
      for (int i = 0; i < count; i++) data_bytes.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wen"}, W'(upg_wen_o), W'(0));
      check({tag, "_adr"}, W'(upg_adr_o), W'(0));
      check({tag, "_dat"}, W'(upg_dat_o), W'(0));
      check({tag, "_done"}, W'(upg_done_o), W'(0));
      check({tag, "_err"}, W'(err_o), W'(0));
      check({tag, "_busy"}, W'(busy_o), W'(0));
      check({tag, "_cpu_rstn"}, W'(cpu_rstn_o), W'(0));
      check({tag, "_state"}, W'(state_o), W'(ST_IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int cnt;

      idle(3);
      rstn = 1'b1;
      check_all_zero("reset");
      mon_en = 1'b1;

      // Bytes without a start are ignored.
      for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
      idle(1);
      check("idle_busy", W'(busy_o), W'(0));

      // Two-word image with known contents.
      data_bytes = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_session(2, 1, 1'b0);
      end_check(1'b1, 1'b0);

      // Empty image completes without writes.
      data_bytes.delete();
      run_session(0, 1, 1'b0);
      end_check(1'b1, 1'b0);

      // Image one word larger than the ROM: rejected, payload ignored.
      fill_random(8);
      run_session(MAX_N + 1, 0, 1'b0);
      end_check(1'b0, 1'b1);

      // Largest header value: rejected.
      data_bytes.delete();
      run_session(16'hFFFF, 0, 1'b0);
      end_check(1'b0, 1'b1);

      // Image exactly the ROM depth is accepted (only two words sent).
      fill_random(8);
      run_session(MAX_N, 0, 1'b0);
      idle(2);
      check("full_depth_busy", W'(busy_o), W'(1));
      check("full_depth_err", W'(err_o), W'(0));

      // Restart mid-payload (byte sent with start is dropped), then N=1.
      fill_random(6);
      run_session(3, 1, 1'b0);
      idle(2);
      check("partial_busy", W'(busy_o), W'(1));
      check("partial_done", W'(upg_done_o), W'(0));
      data_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_session(1, 1, 1'b1);
      end_check(1'b1, 1'b0);

      // Reset mid-session discards the partial word.
      fill_random(5);
      run_session(2, 0, 1'b0);
      tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check_all_zero("midreset");
      for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
      idle(2);
      check("post_reset_busy", W'(busy_o), W'(0));
      check("post_reset_done", W'(upg_done_o), W'(0));
      check("post_reset_drained", W'(exp_q.size()), W'(0));

      // Back-to-back bytes, four words.
      fill_random(16);
      run_session(4, 0, 1'b0);
      end_check(1'b1, 1'b0);

      // Randomized sessions: complete, over-long and truncated streams.
      for (int s = 0; s < 12; s++) begin
         n = (s % 6 == 5) ? 0 : $urandom_range(1, 10);
         if ($urandom_range(0, 3) == 0 && n > 0) cnt = $urandom_range(0, 4 * n - 1);
         else cnt = 4 * n + $urandom_range(0, 3);
         fill_random(cnt);
         run_session(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         end_check(model_done(n), model_err(n));
      end

      idle(3);
      check("final_drained", W'(exp_q.size()), W'(0));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
